// File: rtl/bank.sv
// -----------------------------------------------------------------------------
// bank -- single-clock register-file bank, one write port and one read port.
//
// Storage is 2**ADDR_W words of DATA_W bits. Both ports can be used in the same
// cycle. Read data is registered and valid one cycle after the request. When no
// read is requested, the read data holds its previous value. A synchronous
// active-low reset clears the read register and every stored word. Any request
// made during reset is dropped.
//
// Optional feature macro: BANK_BYPASS_EN
//   defined   : a same-address read-during-write returns the incoming write data
//               (write-first forwarding).
//   undefined : a same-address read-during-write returns the old stored word
//               (read-first). The write still completes.
//
// Ports
//   vsi_clk              in   1       clock, rising edge
//   vsi_reset_n          in   1       synchronous reset, active low
//   vsi_inputData        in   DATA_W  write data
//   vsi_inputAddr        in   ADDR_W  write address
//   vsi_inputChipSelect  in   1       write enable, active high
//   vsi_outputChipSelect in   1       read enable, active high
//   vsi_outputAddr       in   ADDR_W  read address
//   vsi_outputData       out  DATA_W  registered read data
// -----------------------------------------------------------------------------
module bank #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset_n,
  input  logic [DATA_W-1:0] vsi_inputData,
  input  logic [ADDR_W-1:0] vsi_inputAddr,
  input  logic              vsi_inputChipSelect,
  input  logic              vsi_outputChipSelect,
  input  logic [ADDR_W-1:0] vsi_outputAddr,
  output logic [DATA_W-1:0] vsi_outputData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              same_addr;

  assign same_addr = vsi_inputChipSelect && (vsi_inputAddr == vsi_outputAddr);

  always_comb begin
    rdata_d = rdata_q;
    if (vsi_outputChipSelect) begin
      rdata_d = mem_q[vsi_outputAddr];
`ifdef BANK_BYPASS_EN
      if (same_addr) begin
        rdata_d = vsi_inputData;
      end
`endif
    end
  end

  // Only the write-first build looks at same_addr. This keeps it read in
  // both builds.
  logic unused_same_addr;
  assign unused_same_addr = same_addr;

  // The array is built from flops because reset must clear every entry.
  always_ff @(posedge vsi_clk) begin
    if (!vsi_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (vsi_inputChipSelect) begin
        mem_q[vsi_inputAddr] <= vsi_inputData;
      end
      rdata_q <= rdata_d;
    end
  end

  assign vsi_outputData = rdata_q;

endmodule

// File: tb/tb_bank.sv
// -----------------------------------------------------------------------------
// tb_bank -- directed test of bank with default parameters (128 x 128).
// Expected values are hand-computed. The same-address read-during-write
// expectation follows BANK_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_bank;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] waddr;
  logic              wcs;
  logic              rcs;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] exp_rdw;

  bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .vsi_clk              (clk),
    .vsi_reset_n          (rst_n),
    .vsi_inputData        (wdata),
    .vsi_inputAddr        (waddr),
    .vsi_inputChipSelect  (wcs),
    .vsi_outputChipSelect (rcs),
    .vsi_outputAddr       (raddr),
    .vsi_outputData       (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Set the request, let one rising edge sample it, then settle 1 time unit.
  task automatic step(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic re,
                      input logic [ADDR_W-1:0] ra);
    rst_n = r;
    wcs   = we;
    waddr = wa;
    wdata = wd;
    rcs   = re;
    raddr = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ones = '1;
`ifdef BANK_BYPASS_EN
    exp_rdw = ones;
`else
    exp_rdw = '0;
`endif
    rst_n = 1'b0; wcs = 1'b0; rcs = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    #2;

    // Reset for two edges. A write and a read are requested during reset so
    // that we can see they are dropped.
    step(1'b0, 1'b1, 7'd9, 128'hDEAD, 1'b1, 7'd9);
    step(1'b0, 1'b1, 7'd9, 128'hDEAD, 1'b1, 7'd9);
    check_eq("reset_out", rdata, '0);

    // The first edge after reset accepts the request.
    step(1'b1, 1'b1, 7'd1, 128'h0ABCD123, 1'b0, 7'd0);
    check_eq("wr1_no_read", rdata, '0);
    step(1'b1, 1'b1, 7'd2, 128'h1234ABCD, 1'b0, 7'd0);
    check_eq("wr2_no_read", rdata, '0);

    // Write addr 3 and read addr 1 in the same cycle.
    step(1'b1, 1'b1, 7'd3, 128'h123A1BCD, 1'b1, 7'd1);
    check_eq("rd1_during_wr3", rdata, 128'h0ABCD123);

    // Write disabled (to addr 4), read addr 2.
    step(1'b1, 1'b0, 7'd4, 128'h123A1BCA, 1'b1, 7'd2);
    check_eq("rd2", rdata, 128'h1234ABCD);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd4);
    check_eq("rd4_not_written", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd3);
    check_eq("rd3", rdata, 128'h123A1BCD);

    // With read disabled, the output holds, even though the address changes.
    step(1'b1, 1'b0, 7'd0, '0, 1'b0, 7'd1);
    check_eq("hold_no_read", rdata, 128'h123A1BCD);

    // Same-address read-during-write.
    step(1'b1, 1'b1, 7'd5, ones, 1'b1, 7'd5);
    check_eq("rdw_same_addr", rdata, exp_rdw);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd5);
    check_eq("rd5_after_wr", rdata, ones);

    // Top address, with no wrap to 0.
    step(1'b1, 1'b1, 7'd127, 128'h55, 1'b0, 7'd0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd127);
    check_eq("rd127", rdata, 128'h55);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd0);
    check_eq("rd0_no_alias", rdata, '0);

    // Make the output non-zero before the reset.
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd2);
    check_eq("rd2_pre_reset", rdata, 128'h1234ABCD);

    // One reset cycle. A write that coincides with it is dropped.
    step(1'b0, 1'b1, 7'd6, 128'hCAFE, 1'b1, 7'd2);
    check_eq("reset2_out", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd1);
    check_eq("post_rst_rd1", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd2);
    check_eq("post_rst_rd2", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd3);
    check_eq("post_rst_rd3", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd6);
    check_eq("post_rst_rd6_dropped", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd127);
    check_eq("post_rst_rd127", rdata, '0);

    // Write and read at different addresses in the same cycle after reset.
    step(1'b1, 1'b1, 7'd8, 128'h0123456789ABCDEF0011223344556677, 1'b1, 7'd5);
    check_eq("rd5_cleared", rdata, '0);
    step(1'b1, 1'b0, 7'd0, '0, 1'b1, 7'd8);
    check_eq("rd8_full_width", rdata, 128'h0123456789ABCDEF0011223344556677);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bank.md
BANK -- requirements
Module: bank

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 7, SHALL set the address width; depth SHALL be 2**ADDR_W words (128 by default).
REQ-003 vsi_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 vsi_reset_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 vsi_inputData  input  DATA_W  SHALL be the write data.
REQ-006 vsi_inputAddr  input  ADDR_W  SHALL be the write address.
REQ-007 vsi_inputChipSelect  input  1  SHALL be the write enable, active-high.
REQ-008 vsi_outputChipSelect  input  1  SHALL be the read enable, active-high.
REQ-009 vsi_outputAddr  input  ADDR_W  SHALL be the read address.
REQ-010 vsi_outputData  output  DATA_W  SHALL be the registered read data.

Function
REQ-011 Storage SHALL be a 2**ADDR_W x DATA_W array with one write port and one read port, both usable in the same cycle.
REQ-012 Write: at a rising edge with vsi_reset_n=1 and vsi_inputChipSelect=1, mem[vsi_inputAddr] SHALL take vsi_inputData.
REQ-013 Write: with vsi_inputChipSelect=0, the array SHALL NOT change.
REQ-014 Read: at a rising edge with vsi_reset_n=1 and vsi_outputChipSelect=1, vsi_outputData SHALL take mem[vsi_outputAddr].
REQ-015 Read latency SHALL be 1 cycle: data is valid after the edge that samples the read request.
REQ-016 Read: with vsi_outputChipSelect=0, vsi_outputData SHALL hold its previous value.
REQ-017 Read and write at different addresses in the same cycle SHALL both complete with no interaction.
REQ-018 Read and write at the same address in the same cycle SHALL follow REQ-026/REQ-027.
REQ-019 Every address 0..2**ADDR_W-1 SHALL be valid; addresses SHALL NOT wrap or alias.
REQ-020 All inputs SHALL be full-width; no partial or byte-masked writes.

Reset
REQ-021 While vsi_reset_n=0 at a rising edge, vsi_outputData SHALL become 0.
REQ-022 While vsi_reset_n=0 at a rising edge, every array entry SHALL become 0.
REQ-023 While vsi_reset_n=0, read and write requests SHALL be ignored.
REQ-024 A write or read coinciding with reset SHALL be dropped; the array SHALL be all-zero after the reset edge.
REQ-025 The first request SHALL be accepted at the first rising edge with vsi_reset_n=1.

Configuration
REQ-026 With macro BANK_BYPASS_EN defined, a same-address read-during-write SHALL return the new vsi_inputData (write-first forwarding).
REQ-027 Without BANK_BYPASS_EN, a same-address read-during-write SHALL return the old stored word (read-first); the write still completes.

Verification
REQ-028 Reset, then write 0x0ABCD123 to addr 1 and 0x1234ABCD to addr 2 (two cycles, outputChipSelect=0) -> vsi_outputData stays 0.
REQ-029 Next cycle: write 0x123A1BCD to addr 3 while reading addr 1 -> vsi_outputData = 0x0ABCD123 one cycle later.
REQ-030 Next cycle: inputChipSelect=0, inputAddr=4, inputData=0x123A1BCA, read addr 2 -> vsi_outputData = 0x1234ABCD; a later read of addr 4 returns 0.
REQ-031 Write 0xFFFF...FF to addr 5 while reading addr 5 -> returns all-ones with BANK_BYPASS_EN, and 0 (old value) without it; a read of addr 5 next cycle returns all-ones in both builds.
REQ-032 Write 0x55 to addr 127, then read addr 127 and addr 0 -> 0x55, then 0 (no wrap).
REQ-033 Assert vsi_reset_n=0 for one cycle after the writes above -> vsi_outputData = 0; reads of addrs 1, 2, 3 return 0.
